// File: rtl/ov7670_init_pkg.sv
// Shared types and constants for the OV7670 SCCB init sequencer.
package ov7670_init_pkg;

  localparam int unsigned SCCB_WORD_W = 16;

  // COM7 = 0x80: full register reset; always table entry 0.
  localparam logic [SCCB_WORD_W-1:0] SCCB_SOFT_RESET = 16'h1280;

  typedef enum logic [2:0] {
    StPwr,
    StCall,
    StGap,
    StSettle,
    StDone,
    StErr
  } init_state_e;

endpackage

// File: rtl/ov7670_reg_rom.sv
// OV7670 configuration table, {reg_addr, value} per entry.
// Entries at or beyond REG_NUM read as 16'hFFFF.
module ov7670_reg_rom
  import ov7670_init_pkg::*;
#(
  parameter int unsigned REG_NUM = 3
) (
  input  logic [7:0]             addr,
  output logic [SCCB_WORD_W-1:0] data
);

  // Table lookup, masked to the configured length.
  always_comb begin
    data = 16'hFFFF;
    if (32'(addr) < REG_NUM) begin
      case (addr)
        8'd0:    data = SCCB_SOFT_RESET;
        8'd1:    data = 16'h00C7;  // GAIN
        8'd2:    data = 16'h1100;  // CLKRC: no prescale
        8'd3:    data = 16'h1204;  // COM7: RGB output
        8'd4:    data = 16'h8C00;  // RGB444 off
        8'd5:    data = 16'h0400;  // COM1
        8'd6:    data = 16'h40D0;  // COM15: RGB565, full range
        8'd7:    data = 16'h3A04;  // TSLB
        8'd8:    data = 16'h1418;  // COM9: AGC ceiling 4x
        8'd9:    data = 16'h4FB3;  // MTX1
        8'd10:   data = 16'h50B3;  // MTX2
        8'd11:   data = 16'h5100;  // MTX3
        8'd12:   data = 16'h523D;  // MTX4
        8'd13:   data = 16'h53A7;  // MTX5
        8'd14:   data = 16'h54E4;  // MTX6
        8'd15:   data = 16'h589E;  // MTXS
        default: data = 16'hFFFF;
      endcase
    end
  end

endmodule

// File: rtl/ov7670_init_ctrl.sv
// Post-reset OV7670 configuration sequencer: walks the register table and
// issues one SCCB write per entry through sccb_func_module.
module ov7670_init_ctrl
  import ov7670_init_pkg::*;
#(
  parameter int unsigned REG_NUM        = 3,
  parameter int unsigned PWRUP_CYCLES   = 100_000,
  parameter int unsigned SETTLE_CYCLES  = 100_000,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   iRestart,
  input  logic                   iDone,
  output logic                   oCall,
  output logic [SCCB_WORD_W-1:0] oData,
  output logic [7:0]             oIdx,
  output logic                   oBusy,
  output logic                   oInitDone,
  output logic                   oErr
);

  localparam logic [7:0] LastIdx = 8'(REG_NUM - 1);

  init_state_e            state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [7:0]             idx_q, idx_d;
  logic [SCCB_WORD_W-1:0] data_q, data_d;
  logic                   call_q, call_d;
  logic                   busy_q, busy_d;
  logic                   init_done_q, init_done_d;
  logic                   err_q, err_d;
  logic [7:0]             rom_addr;
  logic [SCCB_WORD_W-1:0] rom_data;

  ov7670_reg_rom #(
    .REG_NUM (REG_NUM)
  ) u_rom (
    .addr (rom_addr),
    .data (rom_data)
  );

  // State, shared counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StPwr;
      cnt_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      call_q      <= 1'b0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      call_q      <= call_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  // Next state and shared counter; the counter restarts on every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      // Compared against PWRUP_CYCLES (not -1) so the first call lands
      // PWRUP_CYCLES+1 edges after reset release or restart.
      StPwr: begin
        if (cnt_q == 32'(PWRUP_CYCLES)) state_d = StCall;
      end
      StCall: begin
        if (iDone) begin
          if (idx_q == 8'd0)         state_d = StSettle;
          else if (idx_q == LastIdx) state_d = StDone;
          else                       state_d = StGap;
        end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          state_d = StErr;
        end
      end
      StGap: begin
        if (cnt_q == 32'(GAP_CYCLES - 1)) state_d = StCall;
      end
      StSettle: begin
        if (cnt_q == 32'(SETTLE_CYCLES - 1)) begin
          state_d = (REG_NUM == 1) ? StDone : StCall;
        end
      end
      StDone, StErr: begin
        if (iRestart) state_d = StPwr;
      end
      default: state_d = StPwr;
    endcase

    if (state_d != state_q)                        cnt_d = '0;
    else if (state_q == StDone || state_q == StErr) cnt_d = cnt_q;
    else                                           cnt_d = cnt_q + 32'd1;
  end

  // Output next-values, derived from the transition being taken.
  always_comb begin
    // In GAP/SETTLE the ROM looks one entry ahead so oData is ready on entry.
    rom_addr = (state_q == StGap || state_q == StSettle) ? idx_q + 8'd1 : idx_q;

    idx_d = idx_q;
    if ((state_q == StDone || state_q == StErr) && state_d == StPwr) begin
      idx_d = '0;
    end else if ((state_q == StGap || state_q == StSettle) && state_d == StCall) begin
      idx_d = idx_q + 8'd1;
    end

    data_d = data_q;
    if (state_d == StCall && state_q != StCall) data_d = rom_data;

    call_d      = (state_d == StCall);
    busy_d      = !(state_d == StDone || state_d == StErr);
    init_done_d = (state_d == StDone);
    err_d       = (state_d == StErr);
  end

  assign oCall     = call_q;
  assign oData     = data_q;
  assign oIdx      = idx_q;
  assign oBusy     = busy_q;
  assign oInitDone = init_done_q;
  assign oErr      = err_q;

endmodule

// File: tb/tb_ov7670_init_ctrl.sv
// Directed bench for ov7670_init_ctrl with an in-line SCCB responder.
module tb_ov7670_init_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iRestart = 1'b0;
  logic        iDone = 1'b0;
  logic        oCall;
  logic [15:0] oData;
  logic [7:0]  oIdx;
  logic        oBusy;
  logic        oInitDone;
  logic        oErr;

  int n_checks = 0;
  int n_errs   = 0;
  int edge_cnt = 0;

  ov7670_init_ctrl #(
    .REG_NUM        (3),
    .PWRUP_CYCLES   (20),
    .SETTLE_CYCLES  (50),
    .GAP_CYCLES     (4),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iRestart  (iRestart),
    .iDone     (iDone),
    .oCall     (oCall),
    .oData     (oData),
    .oIdx      (oIdx),
    .oBusy     (oBusy),
    .oInitDone (oInitDone),
    .oErr      (oErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for oCall high; returns the posedge number it rose on.
  task automatic wait_call(input int limit, output int rise);
    int n = 0;
    while (oCall !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq("call_seen", {31'd0, oCall}, 32'd1);
    rise = edge_cnt;
  endtask

  // Serve one write: iDone is sampled 30 edges after oCall rose.
  task automatic serve(input logic [15:0] exp_data, input logic [7:0] exp_idx,
                       input bit restart_mid, output int done_edge);
    bit stable = 1'b1;
    check_eq("call_data", {16'd0, oData}, {16'd0, exp_data});
    check_eq("call_idx", {24'd0, oIdx}, {24'd0, exp_idx});
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      if (oData !== exp_data || oCall !== 1'b1) stable = 1'b0;
      iRestart = (restart_mid && i == 10);
    end
    iDone = 1'b1;
    iRestart = restart_mid;
    @(negedge clk);
    iDone = 1'b0;
    iRestart = 1'b0;
    done_edge = edge_cnt;
    check_eq("call_fall", {31'd0, oCall}, 32'd0);
    check_eq("data_stable", {31'd0, stable}, 32'd1);
  endtask

  initial begin
    int base, rise, d0, d1, d2, r, n;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_call", {31'd0, oCall}, 32'd0);
    check_eq("rst_data", {16'd0, oData}, 32'd0);
    check_eq("rst_idx", {24'd0, oIdx}, 32'd0);
    check_eq("rst_busy", {31'd0, oBusy}, 32'd1);
    check_eq("rst_init", {31'd0, oInitDone}, 32'd0);
    check_eq("rst_err", {31'd0, oErr}, 32'd0);

    // Release, with a spurious iDone during power-up wait
    rst_n = 1'b1;
    base = edge_cnt;
    repeat (5) @(negedge clk);
    iDone = 1'b1;
    @(negedge clk);
    iDone = 1'b0;
    check_eq("pwr_call_low", {31'd0, oCall}, 32'd0);
    check_eq("pwr_idx", {24'd0, oIdx}, 32'd0);
    check_eq("pwr_busy", {31'd0, oBusy}, 32'd1);
    wait_call(100, rise);
    check_eq("first_rise_edge", rise - base, 32'd21);

    // Full run
    serve(16'h1280, 8'd0, 1'b0, d0);
    wait_call(100, rise);
    check_eq("settle_gap", rise - d0, 32'd50);
    serve(16'h00C7, 8'd1, 1'b1, d1);  // restart in CALL and alongside iDone
    @(negedge clk);
    iDone = 1'b1;  // spurious during GAP
    @(negedge clk);
    iDone = 1'b0;
    wait_call(100, rise);
    check_eq("entry_gap", rise - d1, 32'd4);
    check_eq("init_before_last", {31'd0, oInitDone}, 32'd0);
    serve(16'h1100, 8'd2, 1'b0, d2);
    check_eq("done_init", {31'd0, oInitDone}, 32'd1);
    check_eq("done_busy", {31'd0, oBusy}, 32'd0);
    check_eq("done_idx", {24'd0, oIdx}, 32'd2);
    check_eq("done_err", {31'd0, oErr}, 32'd0);

    // Restart from DONE
    iRestart = 1'b1;
    r = edge_cnt + 1;
    @(negedge clk);
    iRestart = 1'b0;
    check_eq("rs_init", {31'd0, oInitDone}, 32'd0);
    check_eq("rs_idx", {24'd0, oIdx}, 32'd0);
    check_eq("rs_busy", {31'd0, oBusy}, 32'd1);
    wait_call(100, rise);
    check_eq("rs_rise_edge", rise - r, 32'd21);

    // Entry 1 never answered
    serve(16'h1280, 8'd0, 1'b0, d0);
    wait_call(100, rise);
    check_eq("to_data", {16'd0, oData}, 32'h00C7);
    n = 0;
    while (oErr !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    check_eq("err_seen", {31'd0, oErr}, 32'd1);
    check_eq("err_edge", edge_cnt - rise, 32'd1000);
    check_eq("err_idx", {24'd0, oIdx}, 32'd1);
    check_eq("err_call", {31'd0, oCall}, 32'd0);
    check_eq("err_busy", {31'd0, oBusy}, 32'd0);

    // Restart from ERR
    iRestart = 1'b1;
    @(negedge clk);
    iRestart = 1'b0;
    check_eq("rs_err_clr", {31'd0, oErr}, 32'd0);
    check_eq("rs_err_idx", {24'd0, oIdx}, 32'd0);
    wait_call(100, rise);
    serve(16'h1280, 8'd0, 1'b0, d0);
    wait_call(100, rise);
    serve(16'h00C7, 8'd1, 1'b0, d1);
    wait_call(100, rise);
    check_eq("e2_idx", {24'd0, oIdx}, 32'd2);

    // Asynchronous reset mid-CALL on entry 2
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_call", {31'd0, oCall}, 32'd0);
    check_eq("async_idx", {24'd0, oIdx}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base = edge_cnt;
    wait_call(100, rise);
    check_eq("rearm_rise_edge", rise - base, 32'd21);
    check_eq("rearm_data", {16'd0, oData}, 32'h1280);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
